// File: rtl/pipeline_pkg.sv
// pipeline_pkg: stage-boundary types and constants shared by the pipeline registers.
package pipeline_pkg;
    localparam int WIDTH = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] pcplus4;
    } if_id_entry_t;
endpackage

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry first-word-fall-through buffer between fetch and decode.
module if_id_queue
    import pipeline_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     ValidF,
    output logic                     ReadyF,
    input  logic [WIDTH-1:0]         InstrF,
    input  logic [WIDTH-1:0]         PCF,
    input  logic [WIDTH-1:0]         PCPlus4F,
    output logic                     ValidD,
    input  logic                     ReadyD,
    output logic [WIDTH-1:0]         InstrD,
    output logic [WIDTH-1:0]         PCD,
    output logic [WIDTH-1:0]         PCPlus4D,
    output logic [$clog2(DEPTH):0]   Count
);
    localparam int AW = $clog2(DEPTH);
    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] pcplus4;
    } entry_t;
    entry_t        mem_q [DEPTH];
    entry_t        head;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push, pop;
    assign ReadyF = cnt_q != (AW+1)'(DEPTH);
    assign ValidD = cnt_q != '0;
    assign Count  = cnt_q;
    assign push   = ValidF && ReadyF && !flush;
    assign pop    = ValidD && ReadyD && !flush;
    assign head   = mem_q[rd_q];
    // Empty queue presents a NOP so stale storage never reaches decode.
    assign InstrD   = ValidD ? head.instr   : WIDTH'(NOP_INSTR);
    assign PCD      = ValidD ? head.pc      : '0;
    assign PCPlus4D = ValidD ? head.pcplus4 : '0;
    always_comb begin
        rd_d  = flush ? '0 : rd_q + AW'(pop);
        wr_d  = flush ? '0 : wr_q + AW'(push);
        cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= '{instr: InstrF, pc: PCF, pcplus4: PCPlus4F};
    end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: randomized and directed checks of if_id_queue against a queue-based model.
module tb_if_id_queue;
    localparam int W = 32;
    localparam int D = 4;
    logic clk = 0, rst_n = 1, flush = 0, ValidF = 0, ReadyD = 0;
    logic ReadyF, ValidD;
    logic [W-1:0] InstrF = '0, PCF = '0, PCPlus4F = '0, InstrD, PCD, PCPlus4D;
    logic [2:0] Count;
    int vectors = 0, miscompares = 0;
    logic [W-1:0] qi[$], qp[$], qp4[$];

    if_id_queue #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .ValidF(ValidF), .ReadyF(ReadyF),
        .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidD(ValidD), .ReadyD(ReadyD),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .Count(Count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int n = qi.size();
        chk("count", 32'(Count), 32'(n));
        chk("validd", 32'(ValidD), 32'(n != 0));
        chk("readyf", 32'(ReadyF), 32'(n != D));
        chk("instrd", InstrD, n != 0 ? qi[0] : 32'h0000_0013);
        chk("pcd", PCD, n != 0 ? qp[0] : 32'h0);
        chk("pcplus4d", PCPlus4D, n != 0 ? qp4[0] : 32'h0);
    endtask

    task automatic model_clear();
        qi.delete();
        qp.delete();
        qp4.delete();
    endtask

    // One clock: drive inputs, apply the queue rules at the edge, compare on the falling edge.
    task automatic cycle(input logic f, input logic v, input logic r, input logic [W-1:0] pc);
        bit do_pop, do_push;
        flush = f; ValidF = v; ReadyD = r;
        PCF = pc; PCPlus4F = pc + 4; InstrF = $urandom;
        @(posedge clk);
        if (f) model_clear();
        else begin
            do_pop  = r && qi.size() != 0;
            do_push = v && qi.size() != D;
            if (do_pop) begin
                void'(qi.pop_front());
                void'(qp.pop_front());
                void'(qp4.pop_front());
            end
            if (do_push) begin
                qi.push_back(InstrF);
                qp.push_back(PCF);
                qp4.push_back(PCPlus4F);
            end
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [W-1:0] pc;
        #7 rst_n = 0;
        #1 model_clear();
        check_all();
        @(negedge clk) rst_n = 1;
        cycle(0, 0, 1, 32'h0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 32'h100 + 32'(4 * i));
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 32'h0);
        pc = 32'h200;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1, 1, pc);
            pc += 4;
        end
        cycle(0, 0, 1, 32'h0);
        for (int i = 0; i < 12; i++) begin
            cycle(0, (i % 5) < 3, (i % 5) >= 3, pc);
            pc += 4;
        end
        while (qi.size() != 3) cycle(0, qi.size() < 3, qi.size() > 3, 32'h300);
        cycle(1, 1, 1, 32'h400);
        chk("flush_cnt", 32'(Count), 32'h0);
        cycle(0, 1, 0, 32'h500);
        cycle(0, 1, 0, 32'h504);
        ValidF = 1; ReadyD = 0; PCF = 32'h508; PCPlus4F = 32'h50C; InstrF = $urandom;
        @(posedge clk);
        qi.push_back(InstrF); qp.push_back(PCF); qp4.push_back(PCPlus4F);
        #2 rst_n = 0;
        #1 model_clear();
        check_all();
        @(negedge clk);
        ValidF = 0;
        rst_n = 1;
        cycle(0, 1, 0, 32'h600);
        chk("post_reset_pc", PCD, 32'h600);
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(15) == 0, $urandom_range(3) != 0, $urandom_range(2) != 0, $urandom);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised fetch-to-decode buffer that replaces the single-entry IF/ID register with a DEPTH-entry first-word-fall-through queue.
- Each entry carries the instruction, its PC and PC+4.
- Fetch pushes and decode pops under a valid/ready handshake.
- A flush discards every buffered entry and presents a NOP (addi x0,x0,0) to decode.
- The block sits between the instruction memory/PC logic and the decode stage, so fetch can run ahead of a stalled decode.

## Interface
- WIDTH, 32: width of instruction, PC and PC+4 fields.
- DEPTH, 4: number of entries; power of two, ≥ 2.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low; clears all state.
- flush  input  1  discard all entries this cycle (branch/jump redirect).
- ValidF  input  1  fetch offers an entry.
- ReadyF  output  1  queue can accept an entry (not full).
- InstrF  input  WIDTH  fetched instruction.
- PCF  input  WIDTH  PC of InstrF.
- PCPlus4F  input  WIDTH  PC+4 of InstrF.
- ValidD  output  1  head entry is valid.
- ReadyD  input  1  decode consumes the head entry (not stalled).
- InstrD  output  WIDTH  head instruction; NOP_INSTR when empty.
- PCD  output  WIDTH  head PC; 0 when empty.
- PCPlus4D  output  WIDTH  head PC+4; 0 when empty.
- Count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage is a circular buffer with read pointer, write pointer and occupancy counter. Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
- Push fires when ValidF && ReadyF && !flush. The entry is written at the write pointer, which then increments.
- Pop fires when ValidD && ReadyD && !flush. The read pointer increments.
- On a cycle where push and pop both fire, Count is unchanged and both pointers advance.
- ReadyF = (Count != DEPTH). It depends only on registered state, never on ReadyD. When the queue is full, a push in the same cycle as a pop is refused.
- ValidD = (Count != 0).
- InstrD, PCD and PCPlus4D are driven combinationally from the head entry when ValidD. When empty they are forced to NOP_INSTR, 0 and 0, regardless of stale storage contents.
- Flush: at the next edge both pointers and Count return to 0. Any push or pop in the flush cycle is ignored, including an offered fetch entry, because it is on the wrong path.
- Flush has priority over push and pop. Reset has priority over everything.
- ReadyD while empty: ignored, no pointer movement.
- ValidF while full: ignored; fetch must hold the entry until ReadyF.
- Storage contents need no reset; only pointers and Count are reset.

## Timing
- Reset (rst_n low, asynchronous) gives:
  - Count=0, ValidD=0, ReadyF=1;
  - InstrD=NOP_INSTR (0x00000013 for WIDTH=32);
  - PCD=0, PCPlus4D=0.
- Release of rst_n takes effect at the next rising edge; the first push can occur in that cycle.
- Fall-through latency is 1 cycle. An entry pushed at edge N appears on InstrD/ValidD after edge N, so decode can pop it in cycle N+1.
- Sustained throughput is one entry per cycle when ReadyD is held high and Count < DEPTH.
- Flush asserted in cycle N: ValidD=0 and outputs show NOP from edge N onward. A new push is accepted in cycle N+1.
- Outputs change only on clk edges or on rst_n assertion; there is no combinational path from ValidF or ReadyD to any output.

## Structure
- Shared package pipeline_pkg holds:
  - NOP_INSTR constant (32'h0000_0013);
  - packed struct if_id_entry_t {instr, pc, pcplus4}, parametrised by WIDTH via a localparam default of 32.
- The other stage-boundary blocks reuse this package.
- Storage and pointer logic stay inline in one module. The block is too small for a separate FIFO sub-module, and flush semantics are stage-specific.

## Test plan
- Reset then idle: rst_n low mid-cycle → immediately Count=0, ValidD=0, ReadyF=1, InstrD=0x00000013, PCD=0.
- Fill and drain: ReadyD=0, push PC 0x100,0x104,0x108,0x10C → Count=4, ReadyF=0. A fifth push is refused. Then ReadyD=1 → outputs pop in order 0x100..0x10C over 4 cycles, then ValidD=0.
- Streaming: ValidF and ReadyD both high for 20 cycles with PC stepping by 4 → Count stays at 1. PCD lags PCF by one cycle with no bubbles.
- Wrap-around: alternate 3 pushes and 2 pops for 12 cycles → FIFO order is preserved across pointer wrap, and Count matches the reference model every cycle.
- Flush with simultaneous push/pop: Count=3, assert flush with ValidF=1 and ReadyD=1 → next cycle Count=0, ValidD=0, InstrD=0x00000013. The flush-cycle fetch entry never appears.
- Reset mid-operation: Count=2 while pushing, drop rst_n asynchronously → outputs at reset values without waiting for an edge. After release, the first push appears alone.
